led_chain_ctrl: RTL and testbench
=================================

Name: led_chain_ctrl

Overview:
- Synthesizable controller for a daisy-chain of C_DEV cascaded STP16-class shift-register LED drivers, each with C_N channels.
- Accepts a full frame over a valid/ready handshake and serialises it MSB-first on LED_SDI/LED_Clk, then pulses LED_LE.
- Drives LED_OE as a global-brightness PWM.
- Checks the chain by comparing LED_SDO, returned from the last device, against the previous frame.

Parameters:
C_N, 16, channels per driver device
C_DEV, 2, cascaded devices; TOT = C_N*C_DEV bits per frame
C_DIV, 2, system clocks per LED_Clk half-period (>=1)
C_PWM_W, 8, brightness/PWM counter width

Ports:
Clk  in  1  system clock, all logic on rising edge
Rst_n  in  1  asynchronous active-low reset
Frame_Data  in  TOT  frame; bit TOT-1 is shifted first
Frame_Valid  in  1  frame offered
Frame_Ready  out  1  controller idle, accepts frame
Bright  in  C_PWM_W  global brightness, 0 = off, 2^C_PWM_W-1 = fully on
Blank  in  1  force all LEDs off
Busy  out  1  frame shift/latch in progress
Err_Flag  out  1  sticky loopback mismatch
LED_Clk  out  1  chain shift clock
LED_SDI  out  1  chain serial data
LED_LE  out  1  chain latch enable, active-high
LED_OE  out  1  chain output blank, 1 = outputs off
LED_SDO  in  1  serial data returned from last device

Behaviour:
- Reset (Rst_n=0, asynchronous): LED_Clk=0, LED_SDI=0, LED_LE=0, LED_OE=1, Frame_Ready=0, Busy=0, Err_Flag=0. FSM goes to IDLE, PWM counter=0, the "chain valid" and "prev valid" flags are cleared.
- Reset asserted mid-frame: the partial frame is discarded. LE is never pulsed, so device latches keep old data.
- First rising Clk after Rst_n release: Frame_Ready=1.
- FSM IDLE:
  - Frame_Ready=1.
  - On Frame_Valid & Frame_Ready, Frame_Data is captured into the shift register and the FSM goes to SHIFT; Frame_Ready=0 and Busy=1 from the next cycle.
  - Later changes to Frame_Data are ignored.
- FSM SHIFT, per bit j = 0..TOT-1:
  - LED_SDI = captured bit TOT-1-j, valid for the whole bit.
  - LED_Clk low for C_DIV cycles, then high for C_DIV cycles. Data is stable across the rising edge.
  - SHIFT lasts exactly TOT*2*C_DIV cycles; LED_Clk ends low.
- FSM LATCH:
  - LED_LE=1 for exactly C_DIV cycles, LED_SDI=0.
  - Then IDLE: Busy=0, Frame_Ready=1. Back-to-back frames are accepted on the first IDLE cycle.
  - Frame period = 1 + TOT*2*C_DIV + C_DIV cycles.
  - First completed LATCH sets "chain valid".
- Loopback check:
  - In the last low-phase cycle before rising edge j, sample LED_SDO and compare with bit TOT-1-j of the previous frame.
  - On mismatch, Err_Flag=1 (sticky until reset).
  - Not performed for the first frame after reset ("prev valid"=0).
  - After each LATCH, the captured frame becomes "previous" and "prev valid"=1.
- PWM:
  - Free-running counter 0..2^C_PWM_W-2, wraps to 0; period 2^C_PWM_W-1 cycles.
  - Bright is sampled only when the counter is 0; other changes take effect at the next period start.
  - LED_OE = 1 when any of these holds:
    - "chain valid"=0
    - Blank=1 (registered, takes effect 1 cycle later)
    - counter >= sampled Bright
  - Otherwise LED_OE = 0.
  - Bright=0 gives always blank; Bright=2^C_PWM_W-1 gives always on.
  - PWM runs independently of the FSM; LE may occur during any PWM phase.
- All outputs are registered; no combinational path from inputs to outputs except Frame_Ready, which depends on FSM state only.

Test Plan:
- Reset/idle (C_N=16, C_DEV=2, C_DIV=2, C_PWM_W=8): hold Rst_n=0 for 5 cycles, then release.
  -> During reset: LED_OE=1, LED_Clk=LED_SDI=LED_LE=0, Frame_Ready=0.
  -> Frame_Ready=1 one cycle after release.
  -> LED_OE stays 1 with Bright=255 until the first latch.
- Single frame 0xA5A5_0F0F with the STP16 model chain attached.
  -> 32 LED_Clk pulses, each 2 low / 2 high.
  -> LED_LE high for 2 cycles at cycle 129 after accept.
  -> Device latches hold 0xA5A5 (far device) / 0x0F0F (near device).
  -> Frame_Ready returns at cycle 131.
- Back-to-back frames 0x1234_5678 then 0x8765_4321 with Frame_Valid held high.
  -> Second accepted on the first IDLE cycle.
  -> LED_SDO loopback matches, Err_Flag=0.
  -> The second frame is shifted unchanged even though Frame_Data changes during SHIFT.
- Loopback fault: force LED_SDO=0 during the second frame while the previous frame was 0xFFFF_FFFF.
  -> Err_Flag=1 after the first rising LED_Clk and stays 1.
  -> First frame after reset with LED_SDO forced 0 gives Err_Flag=0.
- PWM: Bright=64 → LED_OE=0 for 64 of every 255 cycles. Bright=0 → LED_OE always 1. Bright=255 → LED_OE always 0. Change Bright mid-period → applies only from the next counter=0. Blank=1 → LED_OE=1 on the next cycle.
- Reset mid-SHIFT (Rst_n low at bit 10).
  -> Outputs go to reset values immediately.
  -> No LE pulse; device latches retain the prior frame.
  -> New frame is accepted normally after release.

Source files
------------

// File: rtl/led_chain_ctrl.sv
// Serialiser for a daisy-chain of STP16-class LED drivers: frame shift, latch
// pulse, global-brightness PWM on LED_OE and an SDO loopback integrity check.
module led_chain_ctrl #(
    parameter int C_N     = 16,
    parameter int C_DEV   = 2,
    parameter int C_DIV   = 2,
    parameter int C_PWM_W = 8
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [C_N*C_DEV-1:0]   Frame_Data,
    input  logic                   Frame_Valid,
    output logic                   Frame_Ready,
    input  logic [C_PWM_W-1:0]     Bright,
    input  logic                   Blank,
    output logic                   Busy,
    output logic                   Err_Flag,
    output logic                   LED_Clk,
    output logic                   LED_SDI,
    output logic                   LED_LE,
    output logic                   LED_OE,
    input  logic                   LED_SDO
);
    localparam int TOT   = C_N * C_DEV;
    localparam int BIT_W = (TOT > 1) ? $clog2(TOT) : 1;
    localparam int DIV_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;
    localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(TOT - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(C_DIV - 1);
    localparam logic [C_PWM_W-1:0] PWM_LAST = C_PWM_W'((2 ** C_PWM_W) - 2);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH} state_t;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic               high_reg, high_next;
    logic [BIT_W-1:0]   bit_reg, bit_next;
    logic [TOT-1:0]     shift_reg, shift_next;
    logic [TOT-1:0]     prev_reg, prev_next;
    logic               prev_valid_reg, prev_valid_next;
    logic               chain_valid_reg, chain_valid_next;
    logic               err_reg, err_next;
    logic               ready_reg, ready_next;
    logic               busy_reg, busy_next;
    logic               led_clk_reg, led_clk_next;
    logic               led_sdi_reg, led_sdi_next;
    logic               led_le_reg, led_le_next;
    logic               led_oe_reg, led_oe_next;
    logic [C_PWM_W-1:0] pwm_cnt_reg, pwm_cnt_next;
    logic [C_PWM_W-1:0] bright_reg, bright_next;

    // Frame and previous-frame registers rotate rather than shift, so after TOT
    // bits each is back in its original order and the frame can become "previous".
    always_comb begin
        state_next       = state_reg;
        div_next         = div_reg;
        high_next        = high_reg;
        bit_next         = bit_reg;
        shift_next       = shift_reg;
        prev_next        = prev_reg;
        prev_valid_next  = prev_valid_reg;
        chain_valid_next = chain_valid_reg;
        err_next         = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (Frame_Valid && ready_reg) begin
                    state_next = ST_SHIFT;
                    shift_next = Frame_Data;
                    div_next   = '0;
                    high_next  = 1'b0;
                    bit_next   = '0;
                end
            end
            ST_SHIFT: begin
                if (div_reg == DIV_LAST) begin
                    div_next = '0;
                    if (!high_reg) begin
                        // Last low-phase cycle: SDO still shows the old chain bit.
                        high_next = 1'b1;
                        if (prev_valid_reg && (LED_SDO != prev_reg[TOT-1]))
                            err_next = 1'b1;
                    end else begin
                        high_next  = 1'b0;
                        shift_next = {shift_reg[TOT-2:0], shift_reg[TOT-1]};
                        prev_next  = {prev_reg[TOT-2:0], prev_reg[TOT-1]};
                        if (bit_reg == BIT_LAST)
                            state_next = ST_LATCH;
                        else
                            bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            ST_LATCH: begin
                if (div_reg == DIV_LAST) begin
                    state_next       = ST_IDLE;
                    div_next         = '0;
                    prev_next        = shift_reg;
                    prev_valid_next  = 1'b1;
                    chain_valid_next = 1'b1;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        led_clk_next = (state_next == ST_SHIFT) && high_next;
        led_sdi_next = (state_next == ST_SHIFT) && shift_next[TOT-1];
        led_le_next  = (state_next == ST_LATCH);
        busy_next    = (state_next != ST_IDLE);
        ready_next   = (state_next == ST_IDLE);
    end

    // Brightness is only picked up at the start of a PWM period.
    always_comb begin
        bright_next  = (pwm_cnt_reg == '0) ? Bright : bright_reg;
        pwm_cnt_next = (pwm_cnt_reg == PWM_LAST) ? '0 : pwm_cnt_reg + 1'b1;
        led_oe_next  = !chain_valid_reg || Blank || (pwm_cnt_reg >= bright_next);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg       <= ST_IDLE;
            div_reg         <= '0;
            high_reg        <= 1'b0;
            bit_reg         <= '0;
            shift_reg       <= '0;
            prev_reg        <= '0;
            prev_valid_reg  <= 1'b0;
            chain_valid_reg <= 1'b0;
            err_reg         <= 1'b0;
            ready_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            led_clk_reg     <= 1'b0;
            led_sdi_reg     <= 1'b0;
            led_le_reg      <= 1'b0;
            led_oe_reg      <= 1'b1;
            pwm_cnt_reg     <= '0;
            bright_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            div_reg         <= div_next;
            high_reg        <= high_next;
            bit_reg         <= bit_next;
            shift_reg       <= shift_next;
            prev_reg        <= prev_next;
            prev_valid_reg  <= prev_valid_next;
            chain_valid_reg <= chain_valid_next;
            err_reg         <= err_next;
            ready_reg       <= ready_next;
            busy_reg        <= busy_next;
            led_clk_reg     <= led_clk_next;
            led_sdi_reg     <= led_sdi_next;
            led_le_reg      <= led_le_next;
            led_oe_reg      <= led_oe_next;
            pwm_cnt_reg     <= pwm_cnt_next;
            bright_reg      <= bright_next;
        end
    end

    assign Frame_Ready = ready_reg;
    assign Busy        = busy_reg;
    assign Err_Flag    = err_reg;
    assign LED_Clk     = led_clk_reg;
    assign LED_SDI     = led_sdi_reg;
    assign LED_LE      = led_le_reg;
    assign LED_OE      = led_oe_reg;

endmodule

// File: tb/tb_led_chain_ctrl.sv
// Bench for led_chain_ctrl: an STP16 chain model hangs on the LED pins and
// frames/brightness are checked against timing derived from the frame rules.
`timescale 1ns/1ps
module tb_led_chain_ctrl;
    localparam int C_N       = 16;
    localparam int C_DEV     = 2;
    localparam int C_DIV     = 2;
    localparam int C_PWM_W   = 8;
    localparam int TOT       = C_N * C_DEV;
    localparam int SHIFT_CYC = TOT * 2 * C_DIV;
    localparam int FRAME_CYC = 1 + SHIFT_CYC + C_DIV;
    localparam int PWM_PER   = (1 << C_PWM_W) - 1;

    logic               Clk = 1'b0;
    logic               Rst_n = 1'b0;
    logic [TOT-1:0]     Frame_Data = '0;
    logic               Frame_Valid = 1'b0;
    logic               Frame_Ready;
    logic [C_PWM_W-1:0] Bright = '1;
    logic               Blank = 1'b0;
    logic               Busy;
    logic               Err_Flag;
    logic               LED_Clk;
    logic               LED_SDI;
    logic               LED_LE;
    logic               LED_OE;
    logic               LED_SDO;

    int n_checks = 0;
    int n_fail   = 0;

    led_chain_ctrl #(.C_N(C_N), .C_DEV(C_DEV), .C_DIV(C_DIV), .C_PWM_W(C_PWM_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Frame_Data(Frame_Data), .Frame_Valid(Frame_Valid),
        .Frame_Ready(Frame_Ready), .Bright(Bright), .Blank(Blank), .Busy(Busy),
        .Err_Flag(Err_Flag), .LED_Clk(LED_Clk), .LED_SDI(LED_SDI), .LED_LE(LED_LE),
        .LED_OE(LED_OE), .LED_SDO(LED_SDO)
    );

    always #5 Clk = ~Clk;

    // Chain of STP16 devices: shift on LED_Clk rise, latch on LE, SDO from far end
    logic [TOT-1:0] chain_sr  = '0;
    logic [TOT-1:0] chain_lat = '0;
    logic           sdo_force = 1'b0;
    int             clk_rises = 0;
    always @(posedge LED_Clk) begin
        chain_sr  <= {chain_sr[TOT-2:0], LED_SDI};
        clk_rises <= clk_rises + 1;
    end
    always @(posedge LED_LE) chain_lat <= chain_sr;
    assign LED_SDO = sdo_force ? 1'b0 : chain_sr[TOT-1];

    // per-cycle record {Err_Flag, LED_OE, LED_Clk, LED_SDI, LED_LE, Busy, Frame_Ready}
    logic [6:0] obs [1:FRAME_CYC];

    // Expected {LED_Clk, LED_SDI, LED_LE, Busy, Frame_Ready} k cycles after accept
    function automatic logic [4:0] exp_wave(input logic [TOT-1:0] d, input int k);
        int j, p;
        if (k <= SHIFT_CYC) begin
            j = (k - 1) / (2 * C_DIV);
            p = (k - 1) % (2 * C_DIV);
            return {p >= C_DIV, d[TOT-1-j], 1'b0, 1'b1, 1'b0};
        end
        if (k <= SHIFT_CYC + C_DIV) return 5'b00110;
        return 5'b00001;
    endfunction

    // Offers one frame (called at a falling edge) and records FRAME_CYC cycles.
    task automatic play_frame(input logic [TOT-1:0] data, input bit keep_valid,
                              output int waited);
        waited = 0;
        while (!Frame_Ready && waited < 1000) begin
            @(negedge Clk);
            waited++;
        end
        if (!Frame_Ready) begin
            waited = -1;
            return;
        end
        Frame_Data  = data;
        Frame_Valid = 1'b1;
        for (int k = 1; k <= FRAME_CYC; k++) begin
            @(negedge Clk);
            if (k == 1 && !keep_valid) Frame_Valid = 1'b0;
            Frame_Data = TOT'($urandom);
            obs[k] = {Err_Flag, LED_OE, LED_Clk, LED_SDI, LED_LE, Busy, Frame_Ready};
        end
    endtask

    task automatic test_reset();
        int oe_low;
        Rst_n = 1'b0;
        repeat (5) @(negedge Clk);
        n_checks++;
        if ({LED_OE, LED_Clk, LED_SDI, LED_LE, Frame_Ready, Busy, Err_Flag} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_outputs: got OE,CLK,SDI,LE,RDY,BUSY,ERR=%b want 1000000",
                     {LED_OE, LED_Clk, LED_SDI, LED_LE, Frame_Ready, Busy, Err_Flag});
        end
        Rst_n = 1'b1;
        #1;
        n_checks++;
        if (Frame_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b want 0", Frame_Ready);
        end
        @(negedge Clk);
        n_checks++;
        if (Frame_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_release: got %b want 1", Frame_Ready);
        end
        oe_low = 0;
        repeat (20) begin
            @(negedge Clk);
            if (LED_OE !== 1'b1) oe_low++;
        end
        n_checks++;
        if (oe_low != 0) begin
            n_fail++;
            $display("FAIL oe_before_latch: got %0d low cycles want 0", oe_low);
        end
        $display("reset/idle done");
    endtask

    task automatic test_single_frame();
        logic [TOT-1:0] d = 32'hA5A5_0F0F;
        int w, r0, oe_low;
        r0 = clk_rises;
        play_frame(d, 1'b0, w);
        n_checks++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL single_accept_wait: got %0d want 0", w);
        end
        for (int k = 1; k <= FRAME_CYC; k++) begin
            n_checks++;
            if (obs[k][4:0] !== exp_wave(d, k)) begin
                n_fail++;
                $display("FAIL single_wave cycle %0d: got %b want %b", k, obs[k][4:0], exp_wave(d, k));
            end
        end
        oe_low = 0;
        for (int k = 1; k <= SHIFT_CYC + C_DIV; k++) if (obs[k][5] !== 1'b1) oe_low++;
        n_checks++;
        if (oe_low != 0) begin
            n_fail++;
            $display("FAIL single_oe_blank: got %0d low cycles want 0", oe_low);
        end
        n_checks++;
        if (clk_rises - r0 != TOT) begin
            n_fail++;
            $display("FAIL single_clk_pulses: got %0d want %0d", clk_rises - r0, TOT);
        end
        n_checks++;
        if (chain_lat[TOT-1 -: C_N] !== 16'hA5A5 || chain_lat[C_N-1:0] !== 16'h0F0F) begin
            n_fail++;
            $display("FAIL single_latch: got far %h near %h want a5a5 0f0f",
                     chain_lat[TOT-1 -: C_N], chain_lat[C_N-1:0]);
        end
        n_checks++;
        if (Err_Flag !== 1'b0) begin
            n_fail++;
            $display("FAIL single_err: got %b want 0", Err_Flag);
        end
        $display("single frame %h latched %h", d, chain_lat);
    endtask

    task automatic test_back_to_back();
        logic [TOT-1:0] d0 = 32'h1234_5678;
        logic [TOT-1:0] d1 = 32'h8765_4321;
        int w0, w1;
        play_frame(d0, 1'b1, w0);
        for (int k = 1; k <= FRAME_CYC; k++) begin
            n_checks++;
            if (obs[k][4:0] !== exp_wave(d0, k)) begin
                n_fail++;
                $display("FAIL b2b_wave0 cycle %0d: got %b want %b", k, obs[k][4:0], exp_wave(d0, k));
            end
        end
        play_frame(d1, 1'b0, w1);
        n_checks++;
        if (w0 < 0 || w1 != 0) begin
            n_fail++;
            $display("FAIL b2b_accept_wait: got %0d/%0d want >=0/0", w0, w1);
        end
        for (int k = 1; k <= FRAME_CYC; k++) begin
            n_checks++;
            if (obs[k][4:0] !== exp_wave(d1, k)) begin
                n_fail++;
                $display("FAIL b2b_wave1 cycle %0d: got %b want %b", k, obs[k][4:0], exp_wave(d1, k));
            end
        end
        n_checks++;
        if (chain_lat !== d1) begin
            n_fail++;
            $display("FAIL b2b_latch: got %h want %h", chain_lat, d1);
        end
        n_checks++;
        if (Err_Flag !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_err: got %b want 0", Err_Flag);
        end
        $display("back-to-back %h then %h latched %h", d0, d1, chain_lat);
    endtask

    task automatic test_random_frames();
        logic [TOT-1:0] d;
        int w;
        for (int i = 0; i < 4; i++) begin
            d = TOT'($urandom);
            play_frame(d, (i < 3), w);
            n_checks++;
            if (w < 0 || chain_lat !== d) begin
                n_fail++;
                $display("FAIL rand_latch %0d: got %h want %h (wait %0d)", i, chain_lat, d, w);
            end
            $display("random frame %0d %h latched %h", i, d, chain_lat);
        end
        n_checks++;
        if (Err_Flag !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_err: got %b want 0", Err_Flag);
        end
    endtask

    task automatic test_pwm();
        int zeros, cnt, b;
        logic prev_oe;
        for (int i = 0; i < 6; i++) begin
            b = (i == 0) ? 64 : (i == 1) ? 0 : (i == 2) ? PWM_PER : $urandom_range(1, PWM_PER - 1);
            Bright = C_PWM_W'(b);
            repeat (PWM_PER + 2) @(negedge Clk);
            zeros = 0;
            repeat (PWM_PER) begin
                @(negedge Clk);
                if (LED_OE === 1'b0) zeros++;
            end
            n_checks++;
            if (zeros != b) begin
                n_fail++;
                $display("FAIL pwm_duty bright %0d: got %0d on-cycles want %0d", b, zeros, b);
            end
            $display("pwm bright %0d on-cycles %0d", b, zeros);
        end
        // find a period start (OE falls at counter 0)
        Bright = 8'd64;
        repeat (PWM_PER + 2) @(negedge Clk);
        cnt = 0;
        do begin
            prev_oe = LED_OE;
            @(negedge Clk);
            cnt++;
        end while (!(prev_oe === 1'b1 && LED_OE === 1'b0) && cnt < 2 * PWM_PER);
        n_checks++;
        if (cnt >= 2 * PWM_PER) begin
            n_fail++;
            $display("FAIL pwm_sync: got no period start in %0d cycles want one", cnt);
        end
        repeat (100) @(negedge Clk);
        Bright = 8'd200;
        zeros = 0;
        repeat (PWM_PER - 101) begin
            @(negedge Clk);
            if (LED_OE === 1'b0) zeros++;
        end
        n_checks++;
        if (zeros != 0) begin
            n_fail++;
            $display("FAIL pwm_raise_midperiod: got %0d on-cycles want 0", zeros);
        end
        zeros = 0;
        repeat (PWM_PER) begin
            @(negedge Clk);
            if (LED_OE === 1'b0) zeros++;
        end
        n_checks++;
        if (zeros != 200) begin
            n_fail++;
            $display("FAIL pwm_raise_next: got %0d on-cycles want 200", zeros);
        end
        repeat (11) @(negedge Clk);
        Bright = 8'd30;
        zeros = 0;
        repeat (PWM_PER - 11) begin
            @(negedge Clk);
            if (LED_OE === 1'b0) zeros++;
        end
        n_checks++;
        if (zeros != 189) begin
            n_fail++;
            $display("FAIL pwm_lower_midperiod: got %0d on-cycles want 189", zeros);
        end
        zeros = 0;
        repeat (PWM_PER) begin
            @(negedge Clk);
            if (LED_OE === 1'b0) zeros++;
        end
        n_checks++;
        if (zeros != 30) begin
            n_fail++;
            $display("FAIL pwm_lower_next: got %0d on-cycles want 30", zeros);
        end
        // Blank response
        Bright = '1;
        repeat (PWM_PER + 2) @(negedge Clk);
        Blank = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (LED_OE !== 1'b1) begin
            n_fail++;
            $display("FAIL blank_on: got OE %b want 1", LED_OE);
        end
        Blank = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (LED_OE !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_off: got OE %b want 0", LED_OE);
        end
        $display("pwm mid-period and blank done");
    endtask

    task automatic test_loopback_fault();
        int w, errs;
        play_frame('1, 1'b0, w);
        n_checks++;
        if (w < 0 || Err_Flag !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_ones_err: got %b want 0 (wait %0d)", Err_Flag, w);
        end
        sdo_force = 1'b1;
        play_frame(TOT'($urandom), 1'b0, w);
        sdo_force = 1'b0;
        n_checks++;
        if (obs[C_DIV][6] !== 1'b0 || obs[C_DIV+1][6] !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_err_timing: got %b%b want 01", obs[C_DIV][6], obs[C_DIV+1][6]);
        end
        repeat (10) @(negedge Clk);
        n_checks++;
        if (Err_Flag !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_err_sticky: got %b want 1", Err_Flag);
        end
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (Err_Flag !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_err_reset: got %b want 0", Err_Flag);
        end
        sdo_force = 1'b1;
        play_frame(TOT'($urandom), 1'b0, w);
        sdo_force = 1'b0;
        errs = 0;
        for (int k = 1; k <= FRAME_CYC; k++) if (obs[k][6] !== 1'b0) errs++;
        n_checks++;
        if (w < 0 || errs != 0) begin
            n_fail++;
            $display("FAIL loop_first_frame: got %0d err cycles want 0 (wait %0d)", errs, w);
        end
        $display("loopback fault detected and first-frame check skipped");
    endtask

    task automatic test_reset_mid_shift();
        logic [TOT-1:0] d1, d2, d3;
        int w, r0;
        d1 = TOT'($urandom);
        d2 = ~d1;
        d3 = TOT'($urandom);
        play_frame(d1, 1'b0, w);
        n_checks++;
        if (w < 0 || chain_lat !== d1) begin
            n_fail++;
            $display("FAIL midrst_pre_latch: got %h want %h", chain_lat, d1);
        end
        r0 = clk_rises;
        Frame_Data  = d2;
        Frame_Valid = 1'b1;
        @(negedge Clk);
        Frame_Valid = 1'b0;
        repeat (4 * 10) @(negedge Clk);
        n_checks++;
        if (clk_rises - r0 != 10) begin
            n_fail++;
            $display("FAIL midrst_bit_pos: got %0d rises want 10", clk_rises - r0);
        end
        #2 Rst_n = 1'b0;
        #1;
        n_checks++;
        if ({LED_OE, LED_Clk, LED_SDI, LED_LE, Frame_Ready, Busy, Err_Flag} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %b want 1000000",
                     {LED_OE, LED_Clk, LED_SDI, LED_LE, Frame_Ready, Busy, Err_Flag});
        end
        repeat (3) @(negedge Clk);
        n_checks++;
        if (chain_lat !== d1) begin
            n_fail++;
            $display("FAIL midrst_latch_kept: got %h want %h", chain_lat, d1);
        end
        Rst_n = 1'b1;
        play_frame(d3, 1'b0, w);
        n_checks++;
        if (w < 0) begin
            n_fail++;
            $display("FAIL midrst_accept: got wait %0d want >=0", w);
        end
        for (int k = 1; k <= FRAME_CYC; k++) begin
            n_checks++;
            if (obs[k][4:0] !== exp_wave(d3, k)) begin
                n_fail++;
                $display("FAIL midrst_wave cycle %0d: got %b want %b", k, obs[k][4:0], exp_wave(d3, k));
            end
        end
        n_checks++;
        if (chain_lat !== d3) begin
            n_fail++;
            $display("FAIL midrst_new_latch: got %h want %h", chain_lat, d3);
        end
        $display("reset mid-shift: kept %h, then latched %h", d1, chain_lat);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_random_frames();
        test_pwm();
        test_loopback_fault();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
